// File: rtl/payload_crc_checker.sv
// payload_crc_checker: counts a runtime-length payload, checks its trailing CRC and keeps saturating packet counters.
module payload_crc_checker #(
  parameter int MAX_PAYLOAD = 48,
  parameter int LEN_W = 6,
  parameter int CRC_BYTES = 2,
  parameter logic [8*CRC_BYTES-1:0] CRC_POLY = 16'h1021,
  parameter logic [8*CRC_BYTES-1:0] CRC_INIT = 16'hFFFF,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             abort,
  input  logic             count_clear,
  output logic             busy,
  output logic             packet_valid,
  output logic             packet_error,
  output logic             len_error,
  output logic [CNT_W-1:0] valid_packet_count,
  output logic [CNT_W-1:0] error_packet_count
);
  localparam int CRC_W = 8 * CRC_BYTES;
  localparam int IDX_W = CRC_BYTES > 1 ? $clog2(CRC_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC} state_t;
  state_t state, state_next;
  logic [LEN_W-1:0] len, byte_cnt;
  logic [CRC_W-1:0] crc, rx_crc, crc_step, rx_next;
  logic [IDX_W-1:0] crc_idx;
  logic len_bad, accept, last_pay, last_crc, valid_next, error_next, len_err_next;
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] c, input logic [7:0] d);
    logic [CRC_W-1:0] r;
    r = c ^ (CRC_W'(d) << (CRC_W - 8));
    for (int i = 0; i < 8; i++) r = r[CRC_W-1] ? (r << 1) ^ CRC_POLY : r << 1;
    return r;
  endfunction
  always_comb begin
    len_bad = payload_len == '0 || {1'b0, payload_len} > (LEN_W+1)'(MAX_PAYLOAD);
    accept = !abort && state == IDLE && start && !len_bad;
    last_pay = state == PAYLOAD && byte_valid && byte_cnt == len - 1'b1;
    last_crc = state == CRC && byte_valid && crc_idx == IDX_W'(CRC_BYTES - 1);
    rx_next = (rx_crc << 8) | CRC_W'(byte_data);
    crc_step = crc8_step(crc, byte_data);
    valid_next = !abort && last_crc && rx_next == crc;
    error_next = !abort && last_crc && rx_next != crc;
    len_err_next = !abort && state == IDLE && start && len_bad;
    state_next = abort ? IDLE : accept ? PAYLOAD : last_pay ? CRC : last_crc ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // abort freezes the datapath; the state register alone returns to IDLE
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      len <= '0;
      byte_cnt <= '0;
      crc <= '0;
      rx_crc <= '0;
      crc_idx <= '0;
      packet_valid <= 1'b0;
      packet_error <= 1'b0;
      len_error <= 1'b0;
      valid_packet_count <= '0;
      error_packet_count <= '0;
    end else begin
      packet_valid <= valid_next;
      packet_error <= error_next;
      len_error <= len_err_next;
      if (accept) begin
        len <= payload_len;
        crc <= CRC_INIT;
        byte_cnt <= '0;
        crc_idx <= '0;
      end
      if (!abort && state == PAYLOAD && byte_valid) begin
        crc <= crc_step;
        byte_cnt <= last_pay ? '0 : byte_cnt + 1'b1;
      end
      if (!abort && state == CRC && byte_valid) begin
        rx_crc <= rx_next;
        crc_idx <= last_crc ? '0 : crc_idx + 1'b1;
      end
      valid_packet_count <= count_clear ? '0 :
        valid_packet_count + CNT_W'(valid_next && !(&valid_packet_count));
      error_packet_count <= count_clear ? '0 :
        error_packet_count + CNT_W'((error_next || len_err_next) && !(&error_packet_count));
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_payload_crc_checker.sv
// tb_payload_crc_checker: directed scenarios for payload_crc_checker with hand-derived expectations.
module tb_payload_crc_checker;
  logic clock = 0, reset = 0, start = 0, byte_valid = 0, abort = 0, count_clear = 0;
  logic [5:0] payload_len = '0;
  logic [7:0] byte_data = '0;
  logic busy, packet_valid, packet_error, len_error;
  logic [3:0] valid_packet_count, error_packet_count;
  logic [7:0] pl [48];
  int errors = 0, checks = 0;

  payload_crc_checker dut (
    .clock(clock), .reset(reset), .start(start), .payload_len(payload_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .abort(abort), .count_clear(count_clear),
    .busy(busy), .packet_valid(packet_valid), .packet_error(packet_error), .len_error(len_error),
    .valid_packet_count(valid_packet_count), .error_packet_count(error_packet_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {pl[i], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? {c[14:0], 1'b0} ^ 16'h1021 : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_data = 8'hA5;
    repeat (gap) step;
    byte_valid = 1;
    byte_data = b;
    step;
    byte_valid = 0;
    byte_data = 8'h5A;
  endtask

  task automatic do_start(input logic [5:0] l);
    start = 1;
    payload_len = l;
    step;
    start = 0;
  endtask

  task automatic send_packet(input int n, input bit bad, input bit gaps, input bit clr_last);
    logic [15:0] c;
    c = crc_model(n);
    for (int i = 0; i < n; i++) send_byte(pl[i], gaps ? int'($urandom_range(0, 2)) : 0);
    send_byte(c[15:8], gaps ? int'($urandom_range(0, 2)) : 0);
    count_clear = clr_last;
    send_byte(c[7:0] ^ {7'b0, bad}, 0);
    count_clear = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({packet_valid, packet_error, len_error} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {packet_valid, packet_error, len_error}); end
    checks++; if ({valid_packet_count, error_packet_count} !== 8'h00) begin errors++; $display("FAIL reset_counts got=%h exp=00", {valid_packet_count, error_packet_count}); end
    reset = 1;
    step;
  endtask

  task automatic test_good_packet;
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    do_start(6'd9);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_start got=%0b exp=1", busy); end
    for (int i = 0; i < 9; i++) send_byte(pl[i], int'($urandom_range(0, 2)));
    send_byte(8'h29, 2);
    checks++; if (busy !== 1'b1 || packet_valid !== 1'b0) begin errors++; $display("FAIL good_before_last got busy=%0b valid=%0b exp busy=1 valid=0", busy, packet_valid); end
    send_byte(8'hB1, 1);
    checks++; if (packet_valid !== 1'b1 || packet_error !== 1'b0) begin errors++; $display("FAIL good_pulse got valid=%0b err=%0b exp 1/0", packet_valid, packet_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_fall got=%0b exp=0", busy); end
    step;
    checks++; if (packet_valid !== 1'b0) begin errors++; $display("FAIL good_pulse_width got=%0b exp=0", packet_valid); end
    checks++; if (valid_packet_count !== 4'd1) begin errors++; $display("FAIL good_count got=%0d exp=1", valid_packet_count); end
  endtask

  task automatic test_bad_crc;
    do_start(6'd9);
    for (int i = 0; i < 9; i++) send_byte(pl[i], int'($urandom_range(0, 2)));
    send_byte(8'h29, 1);
    send_byte(8'hB0, 0);
    checks++; if (packet_error !== 1'b1 || packet_valid !== 1'b0) begin errors++; $display("FAIL bad_pulse got err=%0b valid=%0b exp 1/0", packet_error, packet_valid); end
    step;
    checks++; if (error_packet_count !== 4'd1) begin errors++; $display("FAIL bad_err_count got=%0d exp=1", error_packet_count); end
    checks++; if (valid_packet_count !== 4'd1) begin errors++; $display("FAIL bad_valid_count got=%0d exp=1", valid_packet_count); end
  endtask

  task automatic test_len_error;
    count_clear = 1;
    step;
    count_clear = 0;
    do_start(6'd0);
    checks++; if (len_error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0 got lerr=%0b busy=%0b exp 1/0", len_error, busy); end
    step;
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL len0_width got=%0b exp=0", len_error); end
    do_start(6'd49);
    checks++; if (len_error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len49 got lerr=%0b busy=%0b exp 1/0", len_error, busy); end
    step;
    checks++; if (error_packet_count !== 4'd2 || valid_packet_count !== 4'd0) begin errors++; $display("FAIL len_counts got err=%0d valid=%0d exp 2/0", error_packet_count, valid_packet_count); end
  endtask

  task automatic test_back_to_back;
    do_start(6'd48);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 48; i++) pl[i] = 8'(i * (k + 3) + k);
      send_packet(48, 0, 0, 0);
      checks++; if (packet_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_pulse_%0d got valid=%0b busy=%0b exp 1/0", k, packet_valid, busy); end
      if (k < 15) begin
        do_start(6'd48);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_%0d got busy=%0b exp=1", k, busy); end
      end else step;
      if (k == 13) begin
        checks++; if (valid_packet_count !== 4'd14) begin errors++; $display("FAIL b2b_count14 got=%0d exp=14", valid_packet_count); end
      end
    end
    checks++; if (valid_packet_count !== 4'hF) begin errors++; $display("FAIL b2b_saturate got=%h exp=F", valid_packet_count); end
    do_start(6'd48);
    send_packet(48, 0, 0, 1);
    checks++; if (packet_valid !== 1'b1) begin errors++; $display("FAIL clr_pulse got=%0b exp=1", packet_valid); end
    step;
    checks++; if (valid_packet_count !== 4'h0) begin errors++; $display("FAIL clr_count got=%h exp=0", valid_packet_count); end
  endtask

  task automatic test_abort;
    logic [15:0] c;
    count_clear = 1;
    step;
    count_clear = 0;
    abort = 1;
    do_start(6'd3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_start got busy=%0b exp=0", busy); end
    do_start(6'd0);
    abort = 0;
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL abort_idle_len got lerr=%0b exp=0", len_error); end
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    c = crc_model(3);
    do_start(6'd3);
    send_byte(pl[0], 0);
    start = 1;
    payload_len = 6'd0;
    send_byte(pl[1], 0);
    start = 0;
    checks++; if (len_error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_in_payload got lerr=%0b busy=%0b exp 0/1", len_error, busy); end
    send_byte(pl[2], 1);
    send_byte(c[15:8], 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_crc_state got busy=%0b exp=1", busy); end
    abort = 1;
    send_byte(c[7:0], 0);
    abort = 0;
    checks++; if ({busy, packet_valid, packet_error} !== 3'b000) begin errors++; $display("FAIL abort_crc got=%b exp=000", {busy, packet_valid, packet_error}); end
    step;
    checks++; if ({valid_packet_count, error_packet_count} !== 8'h00) begin errors++; $display("FAIL abort_counts got=%h exp=00", {valid_packet_count, error_packet_count}); end
    do_start(6'd3);
    send_packet(3, 0, 1, 0);
    checks++; if (packet_valid !== 1'b1) begin errors++; $display("FAIL after_abort_pkt got=%0b exp=1", packet_valid); end
  endtask

  task automatic test_async_reset;
    step;
    do_start(6'd0);
    for (int i = 0; i < 5; i++) pl[i] = 8'hC0 + 8'(i);
    do_start(6'd5);
    send_byte(pl[0], 0);
    send_byte(pl[1], 1);
    #2 reset = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%0b exp=0", busy); end
    checks++; if ({valid_packet_count, error_packet_count} !== 8'h00) begin errors++; $display("FAIL async_counts got=%h exp=00", {valid_packet_count, error_packet_count}); end
    step;
    reset = 1;
    step;
    do_start(6'd5);
    send_packet(5, 0, 1, 0);
    checks++; if (packet_valid !== 1'b1) begin errors++; $display("FAIL post_reset_pulse got=%0b exp=1", packet_valid); end
    step;
    checks++; if (valid_packet_count !== 4'd1 || error_packet_count !== 4'd0) begin errors++; $display("FAIL post_reset_counts got valid=%0d err=%0d exp 1/0", valid_packet_count, error_packet_count); end
  endtask

  initial begin
    test_reset;
    test_good_packet;
    test_bad_crc;
    test_len_error;
    test_back_to_back;
    test_abort;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
